// File: rtl/edge_window_sched.sv
// edge_window_sched
// Streams a raster-order 8-bit image through four line buffers and a 5x5
// window register, presents each complete 5x5 neighbourhood to an external
// combinational edge kernel, and registers the kernel result as a
// valid/ready output stream with coordinates, a last flag and a done pulse.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start                 one-cycle pulse that begins a frame (ignored while busy)
//   pix_in/_valid/_ready  input pixel stream, raster order
//   win_out               5x5 window, element (r,c) at bits [(5r+c)*8 +: 8]
//   kern_in               kernel result for win_out (combinational return)
//   out_pix/_x/_y/_last   registered result with window origin and last flag
//   out_valid/out_ready   output handshake
//   busy                  frame in progress
//   done                  one-cycle pulse after the final output is consumed
module edge_window_sched #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    pix_in,
    input  logic          pix_in_valid,
    output logic          pix_in_ready,
    output logic [199:0]  win_out,
    input  logic [7:0]    kern_in,
    output logic [7:0]    out_pix,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LB_D  = 1 << LB_AW;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
    localparam logic [CW-1:0] EDGE    = CW'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   row;
    logic [CW-1:0]   col;

    logic            adv;
    logic            acc;
    logic            col_last;
    logic            row_last;
    logic            in_win;
    logic [LB_AW-1:0] lb_idx;

    // Line buffers: lb[0] holds the oldest row, lb[3] the most recent.
    logic [7:0]      lb [0:3][0:LB_D-1];

    // Stage 1: window register and its qualifiers.
    logic [7:0]      win_p1 [0:4][0:4];
    logic            vld_p1;
    logic [CW-1:0]   x_p1;
    logic [CW-1:0]   y_p1;
    logic            last_p1;

    assign adv          = !out_valid || out_ready;
    assign pix_in_ready = (state == S_RUN) && adv;
    assign acc          = pix_in_valid && pix_in_ready;
    assign col_last     = (col == COL_MAX);
    assign row_last     = (row == ROW_MAX);
    assign in_win       = (row >= EDGE) && (col >= EDGE);
    assign lb_idx       = col[LB_AW-1:0];

    genvar gr, gc;
    generate
        for (gr = 0; gr < 5; gr++) begin : g_row
            for (gc = 0; gc < 5; gc++) begin : g_col
                assign win_out[(5*gr+gc)*8 +: 8] = win_p1[gr][gc];
            end
        end
    endgenerate

    // Frame control: state, raster counters, busy and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            row   <= '0;
            col   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (acc) begin
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                row   <= '0;
                                state <= S_FLUSH;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Leave once stage 1 is empty and the output register
                    // empties on this edge, so done never overlaps out_valid.
                    if (!vld_p1 && adv) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Line buffers rotate one column per accepted pixel; contents are never
    // observable before being overwritten, so they carry no reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb[0][lb_idx] <= lb[1][lb_idx];
            lb[1][lb_idx] <= lb[2][lb_idx];
            lb[2][lb_idx] <= lb[3][lb_idx];
            lb[3][lb_idx] <= pix_in;
        end
    end

    // Stage 1 data qualifiers (no reset needed; guarded by vld_p1).
    always_ff @(posedge clk) begin
        if (acc) begin
            x_p1    <= col - EDGE;
            y_p1    <= row - EDGE;
            last_p1 <= row_last && col_last;
        end
    end

    // Stage 1 window and valid; stage 2 output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win_p1[r][c] <= 8'd0;
                end
            end
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_pix   <= 8'd0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            if (acc) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        win_p1[r][c] <= win_p1[r][c+1];
                    end
                end
                for (int r = 0; r < 4; r++) begin
                    win_p1[r][4] <= lb[r][lb_idx];
                end
                win_p1[4][4] <= pix_in;
                // The first four columns of every row still hold the tail of
                // the previous row, so they never qualify as a window.
                vld_p1 <= in_win;
            end else begin
                vld_p1 <= 1'b0;
            end

            // ---- stage 1 -> stage 2 ----
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_pix  <= kern_in;
                out_x    <= x_p1;
                out_y    <= y_p1;
                out_last <= last_p1;
            end
        end
    end

endmodule

// File: tb/tb_edge_window_sched.sv
module tb_edge_window_sched;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int CW   = 7;
    localparam int NPIX = W * H;
    localparam int OW   = W - 4;
    localparam int NOUT = (W - 4) * (H - 4);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    pix_in;
    logic          pix_in_valid;
    logic          pix_in_ready;
    logic [199:0]  win_out;
    logic [7:0]    kern_in;
    logic [7:0]    out_pix;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int kmode  = 0;
    logic [7:0] img [NPIX];

    always #5 clk = ~clk;

    edge_window_sched #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
        .win_out(win_out), .kern_in(kern_in),
        .out_pix(out_pix), .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // Bench kernel: either the bottom-right element or a weighted sum of all 25.
    function automatic logic [7:0] ksum(input logic [199:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 25; i++) s += int'(w[i*8 +: 8]) * (i + 1);
        return s[7:0];
    endfunction

    always_comb begin
        kern_in = (kmode != 0) ? ksum(win_out) : win_out[199:192];
    end

    // Reference model: the 5x5 neighbourhood whose top-left pixel is (y,x).
    function automatic logic [199:0] exp_win(input int y, input int x);
        logic [199:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[(5*r+c)*8 +: 8] = img[(y+r)*W + x + c];
        return w;
    endfunction

    function automatic logic [7:0] exp_pix(input int k);
        int y, x;
        y = k / OW;
        x = k % OW;
        if (kmode != 0) return ksum(exp_win(y, x));
        return img[(y+4)*W + x + 4];
    endfunction

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int random_img);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y*W+x] = (random_img != 0) ? 8'($urandom) : 8'(16*y + x);
    endtask

    task automatic run_frame(input int stall, input int gaps, input int chk_lat, input int poke_start);
        int pi, nout, ndone, gap_left, acc44, first_ov, last_hs, prev_acc, tail;
        pi = 0; nout = 0; ndone = 0; gap_left = 0; acc44 = -100;
        first_ov = -1; last_hs = -100; prev_acc = -1; tail = -1;

        @(negedge clk);
        start = 1'b1; pix_in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_after_start", 200'(busy), 200'(1));

        for (int cyc = 0; cyc < 3000 && tail != 0; cyc++) begin
            @(negedge clk);
            if (prev_acc >= 0) begin
                check("win_out", win_out, exp_win(prev_acc / W - 4, prev_acc % W - 4));
            end
            prev_acc = -1;

            out_ready = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (poke_start != 0 && cyc == 15);
            if (gap_left > 0) begin
                pix_in_valid = 1'b0;
                gap_left--;
            end else if (pi < NPIX) begin
                pix_in_valid = 1'b1;
                pix_in       = img[pi];
            end else begin
                pix_in_valid = 1'b0;
            end
            #1;

            if (out_valid && !out_ready) check("ready_in_stall", 200'(pix_in_ready), 200'(0));
            if (done) check("done_with_valid", 200'(out_valid), 200'(0));

            if (done) begin
                ndone++;
                check("done_timing", 200'(cyc), 200'(last_hs + 1));
                check("busy_at_done", 200'(busy), 200'(0));
                if (tail < 0) tail = 5;
            end
            if (tail > 0) tail--;

            if (chk_lat != 0 && out_valid && first_ov < 0) begin
                first_ov = cyc;
                check("latency", 200'(cyc), 200'(acc44 + 2));
            end

            if (out_valid && out_ready) begin
                if (nout < NOUT) begin
                    check("out_pix",  200'(out_pix),  200'(exp_pix(nout)));
                    check("out_x",    200'(out_x),    200'(nout % OW));
                    check("out_y",    200'(out_y),    200'(nout / OW));
                    check("out_last", 200'(out_last), 200'(nout == NOUT - 1));
                end else begin
                    check("extra_output", 200'(nout), 200'(NOUT - 1));
                end
                nout++;
                last_hs = cyc;
            end

            if (pix_in_valid && pix_in_ready) begin
                if (pi == 4*W + 4) acc44 = cyc;
                if ((pi / W) >= 4 && (pi % W) >= 4) prev_acc = pi;
                pi++;
                if (gaps != 0 && $urandom_range(0, 2) == 0) gap_left = $urandom_range(1, 3);
            end
        end
        start = 1'b0; pix_in_valid = 1'b0; out_ready = 1'b1;
        check("frame_complete", 200'(tail == 0), 200'(1));
        check("output_count", 200'(nout), 200'(NOUT));
        check("done_count", 200'(ndone), 200'(1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_in = 8'd0; pix_in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 200'(out_valid), 200'(0));
        check("rst_busy", 200'(busy), 200'(0));
        check("rst_done", 200'(done), 200'(0));
        check("rst_pix_in_ready", 200'(pix_in_ready), 200'(0));
        check("rst_win_out", win_out, 200'(0));
        check("rst_out_pix", 200'(out_pix), 200'(0));
        check("rst_out_xy", 200'({out_x, out_y, out_last}), 200'(0));

        // Counting image, bottom-right-element kernel, free-running.
        fill(0); kmode = 0;
        run_frame(0, 0, 1, 0);

        // Random image, weighted kernel, random output back-pressure.
        fill(1); kmode = 1;
        run_frame(1, 0, 0, 0);

        // Random image, input gaps.
        fill(1);
        run_frame(0, 1, 0, 0);

        // Abort a frame after 20 pixels.
        fill(0); kmode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pix_in_valid = 1'b1; pix_in = img[i];
            #1;
            check("abort_feed_ready", 200'(pix_in_ready), 200'(1));
        end
        @(negedge clk);
        pix_in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 200'(busy), 200'(0));
        check("abort_ready", 200'(pix_in_ready), 200'(0));
        check("abort_out_valid", 200'(out_valid), 200'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_done", 200'(done), 200'(0));
        end
        run_frame(0, 0, 1, 0);

        // Random image, stalls and gaps, start pulsed mid-frame.
        fill(1); kmode = 1;
        run_frame(1, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
